// File: rtl/mult_div_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mult_div_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        CALC   = 2'b01,
        FIXUP  = 2'b10,
        FINISH = 2'b11
    } state_t;

endpackage

// File: rtl/mult_div_abs.sv
// Two's-complement conditional negate: yields |x| for operands and re-applies
// the result sign after the unsigned core.
module mult_div_abs #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val_c
);

    assign o_val_c = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/mult_div_seq.sv
// Iterative signed/unsigned multiply (shift-add) and divide (restoring) unit.
// Optional MULT_DIV_ABORT_EN adds an abort input that flushes CALC/FIXUP.
module mult_div_seq
    import mult_div_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef MULT_DIV_ABORT_EN
    input  logic             abort,
`endif
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;

    logic               w_signed;
    logic               w_is_div;
    logic               w_abort;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_add;
    logic [WIDTH+1:0]   w_shl;
    logic [WIDTH+1:0]   w_sub;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

`ifdef MULT_DIV_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_signed = (op == OP_MULT) || (op == OP_DIV);
    assign w_is_div = (op == OP_DIV) || (op == OP_DIVU);

    // Multiply step: add multiplicand when the multiplier LSB is set, then shift right.
    assign w_add = {1'b0, r_rem[WIDTH-1:0]} + ({1'b0, r_b} & {(WIDTH+1){r_quo[0]}});
    // Divide step: shift in next dividend bit, trial-subtract the divisor.
    assign w_shl = {r_rem, r_quo[WIDTH-1]};
    assign w_sub = w_shl - {2'b00, r_b};

    mult_div_abs #(.W(WIDTH)) u_abs_a (
        .i_val   (a),
        .i_neg   (w_signed & a[WIDTH-1]),
        .o_val_c (w_mag_a)
    );

    mult_div_abs #(.W(WIDTH)) u_abs_b (
        .i_val   (b),
        .i_neg   (w_signed & b[WIDTH-1]),
        .o_val_c (w_mag_b)
    );

    mult_div_abs #(.W(2*WIDTH)) u_fix_prod (
        .i_val   ({r_rem[WIDTH-1:0], r_quo}),
        .i_neg   (r_neg_q),
        .o_val_c (w_prod)
    );

    mult_div_abs #(.W(WIDTH)) u_fix_quo (
        .i_val   (r_quo),
        .i_neg   (r_neg_q),
        .o_val_c (w_quo)
    );

    mult_div_abs #(.W(WIDTH)) u_fix_rem (
        .i_val   (r_rem[WIDTH-1:0]),
        .i_neg   (r_neg_r),
        .o_val_c (w_rem)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_b      <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_is_div <= w_is_div;
                        r_neg_q  <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg_r  <= w_signed & a[WIDTH-1];
                        r_b      <= w_mag_b;
                        r_quo    <= w_mag_a;
                        r_rem    <= '0;
                        if (w_is_div && (b == '0)) begin
                            r_state  <= FINISH;
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            r_cnt   <= CW'(WIDTH);
                            r_state <= CALC;
                            busy    <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    if (w_abort) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        if (r_is_div) begin
                            r_rem <= w_sub[WIDTH+1] ? w_shl[WIDTH:0] : w_sub[WIDTH:0];
                            r_quo <= {r_quo[WIDTH-2:0], ~w_sub[WIDTH+1]};
                        end else begin
                            r_rem <= {1'b0, w_add[WIDTH:1]};
                            r_quo <= {w_add[0], r_quo[WIDTH-1:1]};
                        end
                        r_cnt <= r_cnt - CW'(1);
                        if (r_cnt == CW'(1)) begin
                            r_state <= FIXUP;
                        end
                    end
                end
                FIXUP: begin
                    r_state <= w_abort ? IDLE : FINISH;
                    busy    <= 1'b0;
                    if (!w_abort) begin
                        done <= 1'b1;
                        if (r_is_div) begin
                            hi <= w_rem;
                            lo <= w_quo;
                        end else begin
                            hi <= w_prod[2*WIDTH-1:WIDTH];
                            lo <= w_prod[WIDTH-1:0];
                        end
                    end
                end
                FINISH: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mult_div_seq.md
Name: mult_div_seq

Overview:
Parametrised iterative multiply/divide unit; successor to the fixed 32-bit mult_div used by the multicycle CPU.
- Generalised to WIDTH bits.
- Supports signed and unsigned multiply and divide, selected by op.
- Uses an explicit start/busy/done handshake with a one-cycle divide-by-zero fast path.
- Results feed the CPU's Hi/Lo registers; the control unit stalls on busy and loads Hi/Lo on done.

Parameters:
- WIDTH, 32, operand and result width (must be ≥ 4). Iteration counter width is derived as clog2(WIDTH+1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  operation: 00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU.
- a  input  WIDTH  multiplicand / dividend; sampled with start.
- b  input  WIDTH  multiplier / divisor; sampled with start.
- hi  output  WIDTH  MULT: upper product half. DIV: remainder.
- lo  output  WIDTH  MULT: lower product half. DIV: quotient.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; hi/lo valid in the same cycle.
- div_zero  output  1  one-cycle pulse, coincident with done, for DIV/DIVU with b==0.
- abort  input  1  present only with MULT_DIV_ABORT_EN.

Behaviour:
- Reset (reset==0, async):
  - state=IDLE.
  - hi, lo, busy, done, div_zero, counter and all internal registers = 0.
  - Reset asserted mid-operation discards the operation; no done is produced.
- States: IDLE, CALC, FIXUP, FINISH.
- IDLE:
  - On start=1, latch op, |a|, |b| and result sign flags. Signed ops take magnitudes; unsigned ops pass raw values.
  - DIV/DIVU with b==0: go to FINISH; div_zero=1 with done; hi/lo keep previous values.
  - Otherwise: counter=WIDTH, go to CALC.
- CALC: one iteration per cycle; counter decrements; after WIDTH iterations go to FIXUP.
  - Multiply: radix-2 shift-add on a 2*WIDTH accumulator.
  - Divide: restoring division; remainder register is WIDTH+1 bits.
- FIXUP: apply sign correction (one cycle).
  - MULT: negate the 2*WIDTH product if sign(a)≠sign(b).
  - DIV: quotient negated if signs differ; remainder takes the dividend's sign.
  - Write hi/lo; go to FINISH.
- FINISH: done=1 for one cycle; go to IDLE. busy=0 in this cycle.
- Latency, counting the start cycle as cycle 0:
  - Normal operation: done at cycle WIDTH+2.
  - Divide-by-zero: done at cycle 1.
- Back-to-back: start may be asserted in the cycle done is high. It is not accepted; it must be re-presented in the following IDLE cycle.
- start while busy: ignored; operands are not re-sampled.
- Signed overflow, a = -2^(W-1), b = -1: lo = -2^(W-1) (wraps), hi = 0. No flag.
- a, b and op may change freely after acceptance.
- hi/lo hold their value between operations.

Optional Feature:
MULT_DIV_ABORT_EN
- Defined:
  - Adds the abort input.
  - abort=1 in CALC or FIXUP returns to IDLE next cycle: busy=0, no done, hi/lo unchanged.
  - abort has priority over normal completion; it is ignored in IDLE and FINISH.
  - Supports exception flush by the control unit.
- Undefined: no abort port; every accepted operation runs to completion.

Decomposition:
- Package mult_div_pkg:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - state enum IDLE/CALC/FIXUP/FINISH.
- One natural sub-module: mult_div_abs.
  - Combinational two's-complement magnitude / conditional negate, parametrised width.
  - Instanced for operand magnitudes and result sign fixup.

Test Plan (WIDTH=32):
- MULT a=FFFFFFFD (-3), b=00000005 → done at cycle 34; hi=FFFFFFFF, lo=FFFFFFF1; div_zero=0.
- MULTU a=FFFFFFFF, b=FFFFFFFF → hi=FFFFFFFE, lo=00000001.
- DIV a=FFFFFFF9 (-7), b=00000002 → lo=FFFFFFFD, hi=FFFFFFFF. DIVU a=7, b=2 → lo=3, hi=1.
- DIVU a=7, b=0 → done and div_zero at cycle 1; hi/lo keep previous values. DIV a=80000000, b=FFFFFFFF → lo=80000000, hi=0.
- start pulsed again at cycle 5 with new operands → ignored; original result at cycle 34. reset asserted at cycle 10 → busy=0, hi=lo=0 immediately, no done.
- MULT_DIV_ABORT_EN: abort at cycle 12 → busy=0 at cycle 13, no done, hi/lo unchanged; new start accepted at cycle 13.
